// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the uart_tx_dev serial-transmit peripheral.
// Optional build macro: UART_TX_PARITY_EN adds the even-parity state and CTRL[2] (PEN).
package uart_tx_dev_pkg;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned ST_W = 3;
`else
    localparam int unsigned ST_W = 2;
`endif

    // Transmit FSM encoding
    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = ST_W'(0),
        ST_START  = ST_W'(1),
        ST_DATA   = ST_W'(2),
        ST_STOP   = ST_W'(3)
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = ST_W'(4)
`endif
    } tx_state_e;

    // Register word indices (bridge address bits [3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_IM_BIT   = 0;
    localparam int unsigned CTRL_TXEN_BIT = 1;
    localparam int unsigned CTRL_PEN_BIT  = 2;
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BIT_IDX_W = 3;

endpackage

// File: rtl/uart_tx_dev_baud.sv
// Bit-period generator for uart_tx_dev: counts 0..DIV and pulses a tick on the last count.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_bit_tick_c
);

    logic [DIV_W-1:0] r_cnt;

    assign o_bit_tick_c = !i_clr && (r_cnt == i_div);

    // Counter restarts on clear and on every bit boundary
    always_ff @(posedge clk) begin
        if (rst || i_clr || o_bit_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with programmable bit period and completion IRQ.
// Optional build macro: UART_TX_PARITY_EN (even parity bit when CTRL[2] PEN is set).
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int unsigned      DIV_W       = 16,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(433)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        tx,
    output logic        irq
);

    tx_state_e             r_state;
    tx_state_e             w_state_nxt;
    logic                  r_im;
    logic                  r_txen;
    logic                  r_done;
    logic                  r_tx;
    logic [BYTE_W-1:0]     r_data;
    logic [BYTE_W-1:0]     r_shift;
    logic [BIT_IDX_W-1:0]  r_idx;
    logic [DIV_W-1:0]      r_div;

    logic w_busy;
    logic w_start;
    logic w_bit_tick;
    logic w_tx_nxt;
    logic w_shift_en;
    logic w_done_set;
    logic w_pen;
    logic w_unused;

`ifdef UART_TX_PARITY_EN
    logic r_pen;
    logic r_pen_frame;
    assign w_pen = r_pen;
`else
    assign w_pen = 1'b0;
`endif

    assign w_busy   = (r_state != ST_IDLE);
    assign w_start  = we && (addr == REG_DATA) && !w_busy && r_txen;
    assign tx       = r_tx;
    assign irq      = r_im & r_done;
    assign w_unused = ^din;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (!w_busy),
        .i_div        (r_div),
        .o_bit_tick_c (w_bit_tick)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, serial level and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = 1'b1;
        w_shift_en  = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_tick) begin
                    w_shift_en = 1'b1;
                    if (r_idx == BIT_IDX_W'(BYTE_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = r_pen_frame ? ST_PARITY : ST_STOP;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_tx_nxt = ^r_data;
                if (w_bit_tick) w_state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_bit_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_done_set  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Register file, shift register and registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_im    <= 1'b0;
            r_txen  <= 1'b0;
            r_done  <= 1'b0;
            r_tx    <= 1'b1;
            r_data  <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_div   <= DIV_DEFAULT;
`ifdef UART_TX_PARITY_EN
            r_pen       <= 1'b0;
            r_pen_frame <= 1'b0;
`endif
        end else begin
            r_tx <= w_tx_nxt;
            if (we && (addr == REG_CTRL)) begin
                r_im   <= din[CTRL_IM_BIT];
                r_txen <= din[CTRL_TXEN_BIT];
`ifdef UART_TX_PARITY_EN
                r_pen  <= din[CTRL_PEN_BIT];
`endif
            end
            if (w_start) begin
                r_data  <= din[BYTE_W-1:0];
                r_shift <= din[BYTE_W-1:0];
                r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                r_pen_frame <= r_pen;
`endif
            end else if (w_shift_en) begin
                r_shift <= {1'b0, r_shift[BYTE_W-1:1]};
                r_idx   <= r_idx + BIT_IDX_W'(1);
            end
            if (we && (addr == REG_DIV) && !w_busy) begin
                r_div <= din[DIV_W-1:0];
            end
            // Completion set takes priority over a same-cycle STATUS clear
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_start || (we && (addr == REG_STATUS))) begin
                r_done <= 1'b0;
            end
        end
    end

    // Combinational read mux
    always_comb begin
        dout = '0;
        case (addr)
            REG_CTRL: begin
                dout[CTRL_IM_BIT]   = r_im;
                dout[CTRL_TXEN_BIT] = r_txen;
                dout[CTRL_PEN_BIT]  = w_pen;
            end
            REG_DATA: dout = 32'(r_data);
            REG_STATUS: begin
                dout[STAT_BUSY_BIT] = w_busy;
                dout[STAT_DONE_BIT] = r_done;
            end
            default: dout = 32'(r_div);
        endcase
    end

endmodule
